// File: rtl/int_to_fp_encoder_if.sv
// Handshake and data bundle between an operand producer and the
// integer-to-float encoder.
interface int_to_fp_encoder_if;
    logic        start;
    logic [31:0] int_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    modport master (
        output start,
        output int_in,
        input  busy,
        input  done,
        input  data_out,
        input  status_out
    );

    modport slave (
        input  start,
        input  int_in,
        output busy,
        output done,
        output data_out,
        output status_out
    );
endinterface

// File: rtl/int_to_fp_encoder.sv
// Multi-cycle 32-bit integer to FPU operand encoder.
// Normalises one bit per clock and rounds to nearest even.
module int_to_fp_encoder #(
    parameter int BIAS      = 31,
    parameter bit SIGNED_IN = 1'b1
) (
    input logic                clock100KHz,
    input logic                reset,
    int_to_fp_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ABS,
        NORM,
        ROUND
    } state_t;

    localparam logic [5:0] EXP_TOP    = 6'(BIAS + 31);
    localparam logic [3:0] ST_EXACT   = 4'd0;
    localparam logic [3:0] ST_INEXACT = 4'd1;

    state_t      state;
    logic [31:0] mag;
    logic [5:0]  exp;
    logic        sign;

    logic [24:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [25:0] frac_sum;
    logic        negate;

    // Rounding fields of the normalised magnitude; bit 31 is the hidden one.
    assign frac     = mag[30:6];
    assign guard    = mag[5];
    assign sticky   = |mag[4:0];
    assign round_up = guard & (sticky | frac[0]);
    assign frac_sum = {1'b0, frac} + 26'(round_up);
    assign negate   = SIGNED_IN & mag[31];

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            mag            <= 32'd0;
            exp            <= 6'd0;
            sign           <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.data_out   <= 32'd0;
            bus.status_out <= ST_EXACT;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mag      <= bus.int_in;
                        bus.busy <= 1'b1;
                        state    <= ABS;
                    end
                end
                ABS: begin
                    sign  <= negate;
                    mag   <= negate ? -mag : mag;
                    exp   <= EXP_TOP;
                    state <= NORM;
                end
                NORM: begin
                    if (mag == 32'd0) begin
                        bus.data_out   <= 32'd0;
                        bus.status_out <= ST_EXACT;
                        bus.done       <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else if (mag[31]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - 6'd1;
                    end
                end
                ROUND: begin
                    // A carry out of the fraction bumps the exponent and
                    // leaves the fraction at zero.
                    bus.data_out <= {sign,
                                     exp + 6'(frac_sum[25]),
                                     frac_sum[24:0]};
                    bus.status_out <= (guard | sticky) ? ST_INEXACT
                                                       : ST_EXACT;
                    bus.done       <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
